// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

  localparam int PC_ADDR_W = 32;
  localparam int PC_INC    = 4;

  typedef enum logic {
    RUN,
    HALTED
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_HOLD
  } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selector: sequential, relative branch, absolute jump or hold.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int          ADDR_W = PC_ADDR_W,
  parameter int unsigned INC    = PC_INC
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_e           sel,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc_nxt
);

  // Arithmetic wraps modulo 2^ADDR_W by construction of the widths.
  always_comb begin
    pc_nxt = pc;
    case (sel)
      SEL_SEQ:  pc_nxt = pc + ADDR_W'(INC);
      SEL_BR:   pc_nxt = pc + branch_offset;
      SEL_JMP:  pc_nxt = jump_addr;
      SEL_HOLD: pc_nxt = pc;
      default:  pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with clock-enable style stall/halt hold.
// Optional PC_INSTR_COUNT_EN adds a saturating committed-instruction counter.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int unsigned       INC        = PC_INC,
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt_int,
  input  logic              halt_ext,
  input  logic              resume,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
`ifdef PC_INSTR_COUNT_EN
  output logic [CNT_W-1:0]  instr_count,
`endif
  output logic              pc_valid,
  output logic              halted
);

  pc_state_e         state;
  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_nxt;
  logic              commit;

  assign commit      = (state == RUN) & ~halt_ext & ~stall;
  assign pc_valid    = commit & ~reset;
  assign halted      = (state == HALTED) | halt_ext;
  assign pc_plus_inc = pc + ADDR_W'(INC);

  // halt_int outranks jump/branch: the halt instruction itself falls through.
  always_comb begin
    sel = SEL_HOLD;
    if (commit) begin
      if (halt_int)          sel = SEL_SEQ;
      else if (jump)         sel = SEL_JMP;
      else if (branch_taken) sel = SEL_BR;
      else                   sel = SEL_SEQ;
    end
  end

  pc_next_mux #(.ADDR_W(ADDR_W), .INC(INC)) u_mux (
    .pc            (pc),
    .sel           (sel),
    .jump_addr     (jump_addr),
    .branch_offset (branch_offset),
    .pc_nxt        (pc_nxt)
  );

  // resume is honoured in HALTED even under stall or halt_ext.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_ADDR;
      state <= RUN;
    end else begin
      pc <= pc_nxt;
      case (state)
        RUN:     if (commit && halt_int) state <= HALTED;
        HALTED:  if (resume)             state <= RUN;
        default:                         state <= RUN;
      endcase
    end
  end

`ifdef PC_INSTR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            instr_count <= '0;
    else if (pc_valid && ~&instr_count)   instr_count <= instr_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; counter checks active with PC_INSTR_COUNT_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, halt_int, halt_ext, resume, jump, branch_taken;
  logic [31:0] jump_addr, branch_offset;
  logic [31:0] pc, pc_plus_inc;
  logic        pc_valid, halted;
`ifdef PC_INSTR_COUNT_EN
  logic [3:0]  instr_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W     (32),
    .RESET_ADDR (32'h0),
    .INC        (4),
`ifdef PC_INSTR_COUNT_EN
    .CNT_W      (4)
`else
    .CNT_W      (32)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .halt_int      (halt_int),
    .halt_ext      (halt_ext),
    .resume        (resume),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
`ifdef PC_INSTR_COUNT_EN
    .instr_count   (instr_count),
`endif
    .pc_valid      (pc_valid),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; halt_int = 0; halt_ext = 0; resume = 0;
    jump = 0; branch_taken = 0; jump_addr = '0; branch_offset = '0;
  endtask

  task automatic go_to(input logic [31:0] a);
    clr(); jump = 1; jump_addr = a;
    cyc();
    clr();
  endtask

  initial begin
    clr();
    reset = 1;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    #9 reset = 0;
    #1;
    chk("run_valid", {31'b0, pc_valid}, 32'd1);

    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("seq%0d", i), pc, 32'(i * 4));
    end
    chk("seq_halted", {31'b0, halted}, 32'd0);
    chk("seq_link", pc_plus_inc, 32'h14);

    branch_taken = 1; branch_offset = 32'hFFFF_FFF8;
    cyc();
    chk("branch_neg", pc, 32'h08);
    jump = 1; jump_addr = 32'h100;
    cyc();
    clr();
    chk("jump_wins", pc, 32'h100);
    chk("jump_link", pc_plus_inc, 32'h104);

    // halt with jump and resume present: halt wins, falls through
    go_to(32'h20);
    halt_int = 1; jump = 1; jump_addr = 32'h500; resume = 1;
    cyc();
    clr();
    chk("halt_pc", pc, 32'h24);
    chk("halt_flag", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("halt_hold%0d", i), pc, 32'h24);
    end
    chk("halt_valid", {31'b0, pc_valid}, 32'd0);
    resume = 1;
    cyc();
    resume = 0;
    chk("resume_flag", {31'b0, halted}, 32'd0);
    chk("resume_pc", pc, 32'h24);
    cyc();
    chk("resume_adv", pc, 32'h28);

    go_to(32'h40);
    stall = 1; jump = 1; jump_addr = 32'h900;
    #1;
    chk("stall_valid", {31'b0, pc_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("stall_hold%0d", i), pc, 32'h40);
    end
    clr();
    halt_ext = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("hext_hold%0d", i), pc, 32'h40);
      chk($sformatf("hext_flag%0d", i), {31'b0, halted}, 32'd1);
    end
    halt_ext = 0;
    cyc();
    chk("hext_release", pc, 32'h44);

    stall = 1; halt_int = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("stall_hint%0d", i), pc, 32'h44);
    end
    chk("stall_hint_flag", {31'b0, halted}, 32'd0);
    clr();
    cyc();
    chk("stall_hint_after", pc, 32'h48);
    chk("stall_hint_after_h", {31'b0, halted}, 32'd0);

    // resume under halt_ext leaves the overlay asserted
    halt_int = 1;
    cyc();
    clr();
    chk("halt2_pc", pc, 32'h4C);
    halt_ext = 1; resume = 1;
    cyc();
    resume = 0;
    chk("hext_resume_flag", {31'b0, halted}, 32'd1);
    chk("hext_resume_pc", pc, 32'h4C);
    halt_ext = 0;
    #1;
    chk("hext_resume_run", {31'b0, pc_valid}, 32'd1);
    cyc();
    chk("hext_resume_adv", pc, 32'h50);

    halt_int = 1;
    cyc();
    clr();
    stall = 1; resume = 1;
    cyc();
    clr();
    chk("stall_resume_flag", {31'b0, halted}, 32'd0);
    chk("stall_resume_pc", pc, 32'h54);
    cyc();
    chk("stall_resume_adv", pc, 32'h58);

    go_to(32'hFFFF_FFFC);
    chk("wrap_link", pc_plus_inc, 32'h0);
    cyc();
    chk("wrap_pc", pc, 32'h0);

    halt_int = 1;
    cyc();
    clr();
    chk("halt3_flag", {31'b0, halted}, 32'd1);
    #2 reset = 1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_halted", {31'b0, halted}, 32'd0);
    #1 reset = 0;
    #1;
    chk("async_run", {31'b0, pc_valid}, 32'd1);
    cyc();
    chk("async_adv", pc, 32'h4);

`ifdef PC_INSTR_COUNT_EN
    reset = 1;
    #1;
    chk("cnt_rst", {28'b0, instr_count}, 32'd0);
    reset = 0;
    stall = 1;
    cyc(); cyc();
    chk("cnt_stall", {28'b0, instr_count}, 32'd0);
    stall = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("cnt_5", {28'b0, instr_count}, 32'd5);
    stall = 1;
    for (int i = 0; i < 3; i++) cyc();
    chk("cnt_stall5", {28'b0, instr_count}, 32'd5);
    stall = 0;
    for (int i = 0; i < 20; i++) cyc();
    chk("cnt_sat", {28'b0, instr_count}, 32'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer. It generates the fetch address each cycle. It selects between sequential, relative-branch and absolute-jump next addresses. Pipeline stalls and halts are handled through a clock-enable style hold, never by gating the clock. Halts come from two sources: an internal halt instruction, which latches until a resume pulse, and an external level halt. The block sits at the front of the single-cycle/multicycle datapath and replaces the earlier gated-clock PC unit.

Parameters:
ADDR_W, 32, width of PC and all address/offset ports
RESET_ADDR, 0, PC value loaded on reset
INC, 4, sequential increment added to PC (bytes per instruction)
CNT_W, 32, width of instruction counter (used only with the optional feature)

Ports:
clk  in  1  system clock; the only clock, never gated
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC this cycle (pipeline/memory not ready)
halt_int  in  1  halt instruction decoded at current pc
halt_ext  in  1  external halt, level-sensitive
resume  in  1  single-cycle pulse; leaves internal-halt state
jump  in  1  take absolute jump this cycle
jump_addr  in  ADDR_W  absolute target
branch_taken  in  1  take relative branch this cycle
branch_offset  in  ADDR_W  two's-complement offset added to current pc
pc  out  ADDR_W  current fetch address (registered)
pc_plus_inc  out  ADDR_W  pc + INC, combinational (link address)
pc_valid  out  1  pc advances at the next edge (instruction commits)
halted  out  1  block is frozen by either halt source

Behaviour:
- Reset (async, active-high): pc = RESET_ADDR, state = RUN, halted = 0, pc_valid = 0 while reset is held.
- FSM states: RUN, HALTED (internal halt only). halt_ext is an overlay and is not a state.
- Combinational outputs:
  - halted = (state == HALTED) | halt_ext
  - pc_valid = (state == RUN) & ~halt_ext & ~stall & ~reset
- In RUN, with ~halt_ext & ~stall, next pc is chosen by priority:
  1. halt_int: pc <= pc + INC and state <= HALTED; jump and branch are ignored.
  2. jump: pc <= jump_addr.
  3. branch_taken: pc <= pc + branch_offset.
  4. Otherwise: pc <= pc + INC.
- All arithmetic is modulo 2^ADDR_W. Wrap-around is silent, with no flag. jump_addr is used unaligned, as given.
- stall = 1 in RUN: pc holds. halt_int, jump and branch are all ignored because the instruction has not committed.
- halt_ext = 1: pc holds and the state does not change, except that resume in HALTED still moves state to RUN. Release of halt_ext resumes on the following edge with no lost cycle.
- HALTED: pc holds at the address after the halt instruction. resume = 1 moves state to RUN next edge; pc does not change on that edge. resume in RUN is ignored.
- Simultaneous events:
  - halt_int with resume in RUN: the halt is taken and resume is ignored.
  - stall with resume in HALTED: resume is still honoured.
- Latency: a control input sampled at edge N is reflected in pc after edge N; pc_plus_inc has zero latency.
- Reset asserted mid-halt or mid-stall returns the block to RUN at RESET_ADDR immediately, without waiting for a clock edge.

Optional Feature:
Macro PC_INSTR_COUNT_EN.
- Defined: adds output instr_count [CNT_W-1:0]. It resets to 0 and increments on every edge where pc_valid = 1. It saturates at all-ones and never wraps.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pc_pkg:
  - state enum {RUN, HALTED}
  - next-pc select constants SEL_SEQ, SEL_BR, SEL_JMP, SEL_HOLD
  - default ADDR_W and INC constants
- One natural sub-module: pc_next_mux. It is purely combinational and takes pc, the select, jump_addr and branch_offset to produce the next pc. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then 4 free cycles → pc sequence 0, 4, 8, 12, 16; pc_valid = 1; halted = 0.
- Cycles with pc = 0x10 (one action per cycle):
  - branch_taken with offset 0xFFFFFFF8 → pc 0x08.
  - jump with jump_addr 0x100 in the same cycle as branch_taken → pc 0x100 (jump wins).
- pc = 0x20, halt_int = 1 → pc 0x24, halted = 1. Hold 5 cycles → pc stays 0x24. resume pulse → halted = 0 next cycle, then 0x28.
- Each condition applied for 3 cycles at pc = 0x40:
  - stall = 1 → pc holds 0x40, pc_valid = 0.
  - halt_ext = 1 → pc holds 0x40, halted = 1.
  - halt_int asserted during stall → no halt taken.
- pc = 0xFFFFFFFC, free cycle → pc = 0x0 (wrap). Async reset pulse mid-cycle while HALTED → pc = 0 before the next edge, state RUN.
- PC_INSTR_COUNT_EN with CNT_W = 4: run 20 unstalled cycles → instr_count saturates at 15. Stall cycles do not increment it.
